// File: rtl/pc_update_seq.sv
// ---------------------------------------------------------------------------
// pc_update_seq
//
// Multicycle sequencer for the PC-source path of the multicycle MIPS core.
// It takes a single request from the main control FSM and plays out either a
// one-cycle normal PC update (PC+4, branch, jump, jr, rte) or the exception
// entry sequence: save EPC, read the handler vector byte from memory, then
// load PC from MDR.
//
// Parameters
//   MEM_LAT   cycles exc_mem_rd is held before MDR is valid (1..15)
//   VEC_OPC   byte address of the invalid-opcode handler vector
//   VEC_OVF   byte address of the overflow handler vector
//   VEC_DIV   byte address of the divide-by-zero handler vector
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high
//   pc_req      in   request a PC update; sampled only while busy=0
//   pc_kind     in   000 PC+4, 001 branch, 010 jump, 011 jr, 100 rte
//   br_cond     in   branch condition, sampled with pc_req
//   exc_opc     in   invalid-opcode exception, sampled with pc_req
//   exc_ovf     in   overflow exception, sampled with pc_req
//   exc_div     in   divide-by-zero exception, sampled with pc_req
//   PCmux       out  PC source select (000 A, 001 ULAout, 010 SLAC,
//                    011 EPCout, 100 MDRout, 101 ULAresult)
//   PCWrite     out  PC register load enable
//   EPCWrite    out  EPC register load enable (EPC <- ULAresult = PC-4)
//   exc_mem_rd  out  memory read request for the handler vector
//   exc_addr    out  vector address; valid while exc_mem_rd=1
//   exc_cause   out  00 none, 01 opcode, 10 overflow, 11 div0; held
//   busy        out  sequencer not idle
//   done        out  one-cycle pulse when the update is finished
// ---------------------------------------------------------------------------
module pc_update_seq #(
   parameter int unsigned MEM_LAT = 2,
   parameter logic [31:0] VEC_OPC = 32'd253,
   parameter logic [31:0] VEC_OVF = 32'd254,
   parameter logic [31:0] VEC_DIV = 32'd255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pc_req,
   input  logic [2:0]  pc_kind,
   input  logic        br_cond,
   input  logic        exc_opc,
   input  logic        exc_ovf,
   input  logic        exc_div,
   output logic [2:0]  PCmux,
   output logic        PCWrite,
   output logic        EPCWrite,
   output logic        exc_mem_rd,
   output logic [31:0] exc_addr,
   output logic [1:0]  exc_cause,
   output logic        busy,
   output logic        done
);

   // PC source encodings
   localparam logic [2:0] MuxA      = 3'b000;
   localparam logic [2:0] MuxUlaOut = 3'b001;
   localparam logic [2:0] MuxSlac   = 3'b010;
   localparam logic [2:0] MuxEpc    = 3'b011;
   localparam logic [2:0] MuxMdr    = 3'b100;
   localparam logic [2:0] MuxUlaRes = 3'b101;

   // Request kinds
   localparam logic [2:0] KindPc4    = 3'b000;
   localparam logic [2:0] KindBranch = 3'b001;
   localparam logic [2:0] KindJump   = 3'b010;
   localparam logic [2:0] KindJr     = 3'b011;
   localparam logic [2:0] KindRte    = 3'b100;

   // Read-wait counter reload: EXC_RD lasts exactly MEM_LAT cycles
   localparam logic [3:0] LatInit = 4'(MEM_LAT - 1);

   typedef enum logic [2:0] {
      StIdle,
      StUpd,
      StExcEpc,
      StExcRd,
      StExcLd
   } state_e;

   state_e     state;
   logic [3:0] wait_cnt;

   // PC source for a normal update; reserved kinds behave as PC+4
   function automatic logic [2:0] upd_mux(input logic [2:0] kind);
      logic [2:0] m;
      m = MuxUlaRes;
      case (kind)
         KindPc4:    m = MuxUlaRes;
         KindBranch: m = MuxUlaOut;
         KindJump:   m = MuxSlac;
         KindJr:     m = MuxA;
         KindRte:    m = MuxEpc;
         default:    m = MuxUlaRes;
      endcase
      return m;
   endfunction

   // Outputs are registered, so each transition loads the outputs of the
   // state being entered. Because of that, the request's kind and branch
   // condition are consumed on the accept edge and need no separate copy.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= StIdle;
         wait_cnt   <= '0;
         PCmux      <= MuxUlaRes;
         PCWrite    <= 1'b0;
         EPCWrite   <= 1'b0;
         exc_mem_rd <= 1'b0;
         exc_addr   <= '0;
         exc_cause  <= 2'b00;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         // Defaults for every cycle; states below override what they drive
         PCmux      <= MuxUlaRes;
         PCWrite    <= 1'b0;
         EPCWrite   <= 1'b0;
         exc_mem_rd <= 1'b0;
         done       <= 1'b0;

         unique case (state)
            StIdle: begin
               busy <= 1'b0;
               if (pc_req) begin
                  busy <= 1'b1;
                  if (exc_opc || exc_ovf || exc_div) begin
                     // Exceptions override pc_kind; opc > ovf > div
                     state    <= StExcEpc;
                     EPCWrite <= 1'b1;
                     if (exc_opc) begin
                        exc_cause <= 2'b01;
                        exc_addr  <= VEC_OPC;
                     end else if (exc_ovf) begin
                        exc_cause <= 2'b10;
                        exc_addr  <= VEC_OVF;
                     end else begin
                        exc_cause <= 2'b11;
                        exc_addr  <= VEC_DIV;
                     end
                  end else begin
                     state   <= StUpd;
                     PCmux   <= upd_mux(pc_kind);
                     // A not-taken branch finishes without touching PC
                     PCWrite <= !((pc_kind == KindBranch) && !br_cond);
                     done    <= 1'b1;
                  end
               end
            end

            StUpd: begin
               state <= StIdle;
               busy  <= 1'b0;
            end

            StExcEpc: begin
               state      <= StExcRd;
               wait_cnt   <= LatInit;
               exc_mem_rd <= 1'b1;
               busy       <= 1'b1;
            end

            StExcRd: begin
               busy <= 1'b1;
               if (wait_cnt == '0) begin
                  state   <= StExcLd;
                  PCmux   <= MuxMdr;
                  PCWrite <= 1'b1;
                  done    <= 1'b1;
               end else begin
                  wait_cnt   <= wait_cnt - 4'd1;
                  exc_mem_rd <= 1'b1;
               end
            end

            StExcLd: begin
               state <= StIdle;
               busy  <= 1'b0;
            end

            default: begin
               state <= StIdle;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_update_seq.sv
module tb_pc_update_seq;

   localparam int unsigned LAT = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        pc_req;
   logic [2:0]  pc_kind;
   logic        br_cond;
   logic        exc_opc;
   logic        exc_ovf;
   logic        exc_div;
   logic [2:0]  PCmux;
   logic        PCWrite;
   logic        EPCWrite;
   logic        exc_mem_rd;
   logic [31:0] exc_addr;
   logic [1:0]  exc_cause;
   logic        busy;
   logic        done;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pc_update_seq #(
      .MEM_LAT(LAT),
      .VEC_OPC(32'd253),
      .VEC_OVF(32'd254),
      .VEC_DIV(32'd255)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .pc_req    (pc_req),
      .pc_kind   (pc_kind),
      .br_cond   (br_cond),
      .exc_opc   (exc_opc),
      .exc_ovf   (exc_ovf),
      .exc_div   (exc_div),
      .PCmux     (PCmux),
      .PCWrite   (PCWrite),
      .EPCWrite  (EPCWrite),
      .exc_mem_rd(exc_mem_rd),
      .exc_addr  (exc_addr),
      .exc_cause (exc_cause),
      .busy      (busy),
      .done      (done)
   );

   // ---------------- behavioural model: schedule of per-cycle outputs -------
   typedef struct packed {
      logic [2:0]  mux;
      logic        pcw;
      logic        epcw;
      logic        rd;
      logic [31:0] addr;
      logic [1:0]  cause;
      logic        busy;
      logic        done;
   } exp_t;

   exp_t        q[$];
   exp_t        cur;
   bit          seen_rst = 1'b0;
   logic [1:0]  m_cause;
   logic [31:0] m_addr;

   function automatic exp_t mk(input logic [2:0] mux, input logic pcw, input logic epcw,
                               input logic rd, input logic [31:0] addr,
                               input logic [1:0] cause, input logic bsy, input logic dn);
      exp_t e;
      e.mux = mux; e.pcw = pcw; e.epcw = epcw; e.rd = rd;
      e.addr = addr; e.cause = cause; e.busy = bsy; e.done = dn;
      return e;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         q.delete();
         m_cause  = 2'b00;
         m_addr   = 32'd0;
         seen_rst = 1'b1;
         cur <= mk(3'b101, 0, 0, 0, 32'd0, 2'b00, 0, 0);
      end else if (seen_rst && !cur.busy && pc_req) begin
         if (exc_opc || exc_ovf || exc_div) begin
            if (exc_opc)      begin m_cause = 2'b01; m_addr = 32'd253; end
            else if (exc_ovf) begin m_cause = 2'b10; m_addr = 32'd254; end
            else              begin m_cause = 2'b11; m_addr = 32'd255; end
            q.push_back(mk(3'b101, 0, 1, 0, m_addr, m_cause, 1, 0));
            for (int i = 0; i < int'(LAT); i++)
               q.push_back(mk(3'b101, 0, 0, 1, m_addr, m_cause, 1, 0));
            q.push_back(mk(3'b100, 1, 0, 0, m_addr, m_cause, 1, 1));
         end else begin
            logic [2:0] m;
            case (pc_kind)
               3'd1:    m = 3'b001;
               3'd2:    m = 3'b010;
               3'd3:    m = 3'b000;
               3'd4:    m = 3'b011;
               default: m = 3'b101;
            endcase
            q.push_back(mk(m, !(pc_kind == 3'd1 && !br_cond), 0, 0, m_addr, m_cause, 1, 1));
         end
         cur <= q.pop_front();
      end else if (q.size() != 0) begin
         cur <= q.pop_front();
      end else begin
         cur <= mk(3'b101, 0, 0, 0, m_addr, m_cause, 0, 0);
      end
   end

   // Whole-output comparison against the model, every cycle after reset
   always @(negedge clk) begin
      if (seen_rst) begin
         exp_t act;
         act = {PCmux, PCWrite, EPCWrite, exc_mem_rd, exc_addr, exc_cause, busy, done};
         n_tests++;
         if (act !== cur) begin
            n_fail++;
            $display("FAIL model_cmp t=%0t actual=%h required=%h", $time, act, cur);
         end
      end
   end

   // ---------------- directed checks -----------------------------------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Present a one-cycle request; returns just after the accept edge (cycle +1)
   task automatic drive(input logic [2:0] k, input logic br, input logic eo,
                        input logic ev, input logic ed);
      pc_req = 1'b1; pc_kind = k; br_cond = br;
      exc_opc = eo; exc_ovf = ev; exc_div = ed;
      @(posedge clk); #1;
      pc_req = 1'b0; exc_opc = 1'b0; exc_ovf = 1'b0; exc_div = 1'b0;
   endtask

   initial begin
      logic [2:0] kinds [5];
      logic [2:0] muxes [5];
      kinds = '{3'd2, 3'd3, 3'd4, 3'd0, 3'd7};
      muxes = '{3'b010, 3'b000, 3'b011, 3'b101, 3'b101};

      reset = 1'b1; pc_req = 1'b0; pc_kind = 3'd0; br_cond = 1'b0;
      exc_opc = 1'b0; exc_ovf = 1'b0; exc_div = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pcmux", 32'(PCmux), 32'h5);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_cause", 32'(exc_cause), 32'h0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Branch taken / not taken
      drive(3'd1, 1'b1, 0, 0, 0);
      @(negedge clk);
      chk("br_t_mux", 32'(PCmux), 32'h1);
      chk("br_t_pcw", 32'(PCWrite), 32'h1);
      chk("br_t_done", 32'(done), 32'h1);
      @(posedge clk); #1;
      drive(3'd1, 1'b0, 0, 0, 0);
      @(negedge clk);
      chk("br_nt_pcw", 32'(PCWrite), 32'h0);
      chk("br_nt_done", 32'(done), 32'h1);
      @(posedge clk); #1;

      // jump, jr, rte, PC+4, reserved
      for (int i = 0; i < 5; i++) begin
         drive(kinds[i], 1'b0, 0, 0, 0);
         @(negedge clk);
         chk("kind_mux", 32'(PCmux), 32'(muxes[i]));
         chk("kind_pcw", 32'(PCWrite), 32'h1);
         @(posedge clk); #1;
      end

      // Overflow exception, MEM_LAT=2
      drive(3'd0, 1'b0, 0, 1, 0);
      @(negedge clk);
      chk("ovf_epcw", 32'(EPCWrite), 32'h1);
      chk("ovf_pcw0", 32'(PCWrite), 32'h0);
      @(negedge clk);
      chk("ovf_rd2", 32'(exc_mem_rd), 32'h1);
      chk("ovf_addr", exc_addr, 32'd254);
      @(negedge clk);
      chk("ovf_rd3", 32'(exc_mem_rd), 32'h1);
      @(negedge clk);
      chk("ovf_ld_mux", 32'(PCmux), 32'h4);
      chk("ovf_ld_pcw", 32'(PCWrite), 32'h1);
      chk("ovf_ld_done", 32'(done), 32'h1);
      chk("ovf_cause", 32'(exc_cause), 32'h2);
      @(posedge clk); #1;

      // opc+div together with a jump: opcode exception wins
      drive(3'd2, 1'b0, 1, 0, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("opc_no_jump", 32'(PCmux == 3'b010), 32'h0);
         if (i == 1) begin
            chk("opc_addr", exc_addr, 32'd253);
            chk("opc_cause", 32'(exc_cause), 32'h1);
         end
      end
      @(posedge clk); #1;

      // pc_req held through a div0 sequence: no restart until after done
      pc_req = 1'b1; pc_kind = 3'd0; exc_div = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 1) chk("hold_addr", exc_addr, 32'd255);
         if (i == 1 || i == 2) chk("hold_no_restart", 32'(EPCWrite), 32'h0);
         if (i == 3) chk("hold_done", 32'(done), 32'h1);
         if (i == 3) chk("hold_cause", 32'(exc_cause), 32'h3);
         if (i == 4) chk("hold_idle", 32'(busy), 32'h0);
         if (i == 5) chk("hold_restart", 32'(EPCWrite), 32'h1);
      end
      pc_req = 1'b0; exc_div = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      // Reset in the middle of EXC_RD
      drive(3'd0, 1'b0, 0, 1, 0);
      @(negedge clk);
      @(negedge clk);
      chk("mid_rd", 32'(exc_mem_rd), 32'h1);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("ab_pcmux", 32'(PCmux), 32'h5);
      chk("ab_pcw", 32'(PCWrite), 32'h0);
      chk("ab_rd", 32'(exc_mem_rd), 32'h0);
      chk("ab_addr", exc_addr, 32'd0);
      chk("ab_cause", 32'(exc_cause), 32'h0);
      chk("ab_busy", 32'(busy), 32'h0);
      @(posedge clk); #1;
      chk("ab2_pcw", 32'(PCWrite), 32'h0);
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_pcw", 32'(PCWrite), 32'h0);
      chk("post_rst_busy", 32'(busy), 32'h0);
      @(posedge clk); #1;
      drive(3'd0, 1'b0, 0, 0, 0);
      @(negedge clk);
      chk("recover_pcw", 32'(PCWrite), 32'h1);
      chk("recover_done", 32'(done), 32'h1);

      repeat (3) @(posedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
